// File: rtl/spi_pkg.sv
// spi_pkg: shared types and constants for the SPI slave wrapper and its RAM.
// Holds the FSM state encoding, the two-bit command encodings and the default sizes.
package spi_pkg;

    localparam int DEF_MEM_DEPTH = 256;
    localparam int DEF_ADDR_SIZE = 8;

    // Frame body length after the select bit; the counter parks one past the
    // last bit so the completed frame is handed to the RAM exactly once.
    localparam logic [3:0] FRAME_BITS   = 4'd10;
    localparam logic [3:0] BIT_CNT_HOLD = 4'd11;

    localparam int BYTE_BITS = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } spi_state_e;

    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } spi_cmd_e;

    function automatic logic is_frame_state(input spi_state_e s);
        return (s == WRITE) || (s == READ_ADD) || (s == READ_DATA);
    endfunction

endpackage

// File: rtl/spi_ram.sv
// spi_ram: single-port MEM_DEPTH x 8 RAM driven by 10-bit command words from the SPI front end.
// Address registers and the read strobe reset; the storage array deliberately does not.
module spi_ram
    import spi_pkg::*;
#(
    parameter int MEM_DEPTH = DEF_MEM_DEPTH,
    parameter int ADDR_SIZE = DEF_ADDR_SIZE
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [9:0]            din,
    input  logic                  rx_valid,
    output logic [BYTE_BITS-1:0]  dout,
    output logic                  tx_valid
);

    logic [BYTE_BITS-1:0] mem [MEM_DEPTH];
    logic [ADDR_SIZE-1:0] wr_addr;
    logic [ADDR_SIZE-1:0] rd_addr;
    spi_cmd_e             cmd;
    logic [ADDR_SIZE-1:0] payload_addr;

    always_comb begin
        cmd          = spi_cmd_e'(din[9:8]);
        payload_addr = ADDR_SIZE'(din[7:0]);
    end

    always_ff @(posedge clk) begin
        if (rx_valid && (cmd == CMD_WR_DATA)) begin
            mem[wr_addr] <= din[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr  <= '0;
            rd_addr  <= '0;
            dout     <= '0;
            tx_valid <= 1'b0;
        end else begin
            tx_valid <= 1'b0;
            if (rx_valid) begin
                case (cmd)
                    CMD_WR_ADDR: wr_addr <= payload_addr;
                    CMD_RD_ADDR: rd_addr <= payload_addr;
                    CMD_RD_DATA: begin
                        dout     <= mem[rd_addr];
                        tx_valid <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/spi_wrapper.sv
// spi_wrapper: SPI slave that deserialises select-bit + 10-bit frames into spi_ram and shifts
// read bytes back on MISO. Defining SPI_ASSERT_EN compiles the protocol assertions.
module spi_wrapper
    import spi_pkg::*;
#(
    parameter int MEM_DEPTH = DEF_MEM_DEPTH,
    parameter int ADDR_SIZE = DEF_ADDR_SIZE
) (
    input  logic wclk,
    input  logic wrst_n,
    input  logic SS_n,
    input  logic MOSI,
    output logic MISO
);

    spi_state_e           state;
    spi_state_e           next_state;
    logic                 sel_bit;
    logic [3:0]           bit_cnt;
    logic [9:0]           shift_reg;
    logic [9:0]           din;
    logic                 rx_valid;
    logic                 tx_valid;
    logic [BYTE_BITS-1:0] dout;
    logic                 rd_addr_flag;
    logic [BYTE_BITS-1:0] tx_sr;
    logic [2:0]           tx_left;
    logic                 in_frame;
    logic                 shift_en;
    logic                 frame_done;
    logic                 frame_match;

    // rx_valid and tx_valid are one-cycle strobes with no ready: the receiver
    // must act on the rising edge where the strobe is high or the word is lost.

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (SS_n) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    next_state = CHK_CMD;
                CHK_CMD: begin
                    if (!MOSI) begin
                        next_state = WRITE;
                    end else if (rd_addr_flag) begin
                        next_state = READ_DATA;
                    end else begin
                        next_state = READ_ADD;
                    end
                end
                WRITE, READ_ADD, READ_DATA: next_state = state;
                default: next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        in_frame    = is_frame_state(state) && !SS_n;
        shift_en    = in_frame && (bit_cnt < FRAME_BITS);
        frame_done  = in_frame && (bit_cnt == FRAME_BITS);
        frame_match = (shift_reg[9] == sel_bit);
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            sel_bit      <= 1'b0;
            bit_cnt      <= '0;
            shift_reg    <= '0;
            din          <= '0;
            rx_valid     <= 1'b0;
            rd_addr_flag <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if ((state == CHK_CMD) && !SS_n) begin
                sel_bit <= MOSI;
            end
            if (!in_frame) begin
                bit_cnt <= '0;
            end else if (bit_cnt != BIT_CNT_HOLD) begin
                bit_cnt <= bit_cnt + 4'd1;
            end
            if (shift_en) begin
                shift_reg <= {shift_reg[8:0], MOSI};
            end
            // A frame whose leading command bit disagrees with the select bit is dropped whole.
            if (frame_done) begin
                din      <= shift_reg;
                rx_valid <= frame_match;
                if (frame_match && (state == READ_ADD)) begin
                    rd_addr_flag <= 1'b1;
                end else if (frame_match && (state == READ_DATA)) begin
                    rd_addr_flag <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            MISO    <= 1'b0;
            tx_sr   <= '0;
            tx_left <= '0;
        end else if (SS_n || (state != READ_DATA)) begin
            MISO    <= 1'b0;
            tx_sr   <= '0;
            tx_left <= '0;
        end else if (tx_valid) begin
            MISO    <= dout[7];
            tx_sr   <= {dout[6:0], 1'b0};
            tx_left <= 3'd7;
        end else if (tx_left != 3'd0) begin
            MISO    <= tx_sr[7];
            tx_sr   <= {tx_sr[6:0], 1'b0};
            tx_left <= tx_left - 3'd1;
        end else begin
            MISO <= 1'b0;
        end
    end

    spi_ram #(
        .MEM_DEPTH (MEM_DEPTH),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_ram (
        .clk      (wclk),
        .rst_n    (wrst_n),
        .din      (din),
        .rx_valid (rx_valid),
        .dout     (dout),
        .tx_valid (tx_valid)
    );

`ifdef SPI_ASSERT_EN
    a_rx_valid_pulse: assert property (@(posedge wclk) disable iff (!wrst_n)
        rx_valid |=> !rx_valid);

    a_tx_after_read: assert property (@(posedge wclk) disable iff (!wrst_n)
        tx_valid |-> ($past(rx_valid) && ($past(din[9:8]) == CMD_RD_DATA)));

    a_miso_quiet: assert property (@(posedge wclk) disable iff (!wrst_n)
        (state != READ_DATA) |-> !MISO);

    a_state_legal: assert property (@(posedge wclk) disable iff (!wrst_n)
        state inside {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA});
`else
    // Checking logic is compiled only when SPI_ASSERT_EN is defined.
`endif

endmodule

// File: tb/tb_spi_wrapper.sv
// tb_spi_wrapper: table-driven frame vectors plus hand-written abort and reset sequences
// for spi_wrapper; expected values are computed by hand in the vector table.
module tb_spi_wrapper;
    import spi_pkg::*;

    logic wclk;
    logic wrst_n;
    logic SS_n;
    logic MOSI;
    logic MISO;

    int tests;
    int fails;
    int rx_seen;
    int tx_seen;
    logic [31:0] miso_log;

    typedef struct {
        logic       sel;
        logic [9:0] bits;
        int         exp_rx;
        int         exp_tx;
        logic [7:0] exp_byte;
    } vec_t;

    localparam int NVEC = 23;
    vec_t vecs [NVEC];

    spi_wrapper dut (
        .wclk   (wclk),
        .wrst_n (wrst_n),
        .SS_n   (SS_n),
        .MOSI   (MOSI),
        .MISO   (MISO)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_obs();
        rx_seen  = 0;
        tx_seen  = 0;
        miso_log = '0;
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
    task automatic cycle(input logic ss, input logic mosi);
        SS_n = ss;
        MOSI = mosi;
        @(posedge wclk);
        #1;
        if (dut.rx_valid) rx_seen++;
        if (dut.tx_valid) tx_seen++;
        miso_log = {miso_log[30:0], MISO};
    endtask

    task automatic run_frame(input logic sel, input logic [9:0] bits, input int nbits, input int tail);
        clear_obs();
        cycle(1'b0, sel);
        cycle(1'b0, sel);
        for (int i = 0; i < nbits; i++) cycle(1'b0, bits[9-i]);
        for (int i = 0; i < tail; i++) cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
    endtask

    initial begin
        logic [9:0] bits;
        tests = 0;
        fails = 0;
        clear_obs();

        vecs[0]  = '{1'b0, 10'b00_0110_0111, 1, 0, 8'h00};
        vecs[1]  = '{1'b0, 10'b01_1111_1111, 1, 0, 8'h00};
        vecs[2]  = '{1'b1, 10'b10_0110_0111, 1, 0, 8'h00};
        vecs[3]  = '{1'b1, 10'b11_0110_0111, 1, 1, 8'hFF};
        vecs[4]  = '{1'b0, 10'b00_0001_0010, 1, 0, 8'h00};
        vecs[5]  = '{1'b0, 10'b01_1010_0101, 1, 0, 8'h00};
        vecs[6]  = '{1'b1, 10'b10_0001_0010, 1, 0, 8'h00};
        vecs[7]  = '{1'b1, 10'b11_0000_0000, 1, 1, 8'hA5};
        vecs[8]  = '{1'b0, 10'b11_0000_0000, 0, 0, 8'h00};
        vecs[9]  = '{1'b1, 10'b10_0110_0111, 1, 0, 8'h00};
        vecs[10] = '{1'b1, 10'b11_0000_0000, 1, 1, 8'hFF};
        vecs[11] = '{1'b0, 10'b00_1111_1111, 1, 0, 8'h00};
        vecs[12] = '{1'b0, 10'b01_0011_1100, 1, 0, 8'h00};
        vecs[13] = '{1'b1, 10'b10_1111_1111, 1, 0, 8'h00};
        vecs[14] = '{1'b1, 10'b11_0000_0000, 1, 1, 8'h3C};
        vecs[15] = '{1'b0, 10'b00_0000_0000, 1, 0, 8'h00};
        vecs[16] = '{1'b0, 10'b01_1000_0001, 1, 0, 8'h00};
        vecs[17] = '{1'b1, 10'b10_0000_0000, 1, 0, 8'h00};
        vecs[18] = '{1'b1, 10'b11_0000_0000, 1, 1, 8'h81};
        vecs[19] = '{1'b1, 10'b00_0101_0101, 0, 0, 8'h00};
        vecs[20] = '{1'b1, 10'b10_1111_1111, 1, 0, 8'h00};
        vecs[21] = '{1'b1, 10'b01_0000_0000, 0, 0, 8'h00};
        vecs[22] = '{1'b1, 10'b11_0000_0000, 1, 1, 8'h3C};

        // Clock/reset
        wrst_n = 1'b0;
        SS_n   = 1'b1;
        MOSI   = 1'b0;
        repeat (3) @(posedge wclk);
        #1;
        check("reset_miso", 32'(MISO), 32'd0);
        check("reset_state", 32'(dut.state), 32'(IDLE));
        check("reset_dout", 32'(dut.dout), 32'd0);
        check("reset_din", 32'(dut.din), 32'd0);
        wrst_n = 1'b1;
        cycle(1'b1, 1'b0);

        // Table-driven frames; a read byte appears on MISO 3..10 edges after the 10th bit.
        for (int i = 0; i < NVEC; i++) begin
            run_frame(vecs[i].sel, vecs[i].bits, 10, 12);
            check($sformatf("vec%0d_rx", i), 32'(rx_seen), 32'(vecs[i].exp_rx));
            check($sformatf("vec%0d_tx", i), 32'(tx_seen), 32'(vecs[i].exp_tx));
            check($sformatf("vec%0d_miso", i), miso_log, 32'(vecs[i].exp_byte) << 4);
        end

        // SS_n raised after 5 bits of a write-address frame
        run_frame(1'b0, 10'b00_1010_1010, 5, 0);
        check("abort_wr_rx", 32'(rx_seen), 32'd0);
        check("abort_wr_addr", 32'(dut.u_ram.wr_addr), 32'h00);
        check("abort_rd_addr", 32'(dut.u_ram.rd_addr), 32'hFF);
        check("abort_mem0", 32'(dut.u_ram.mem[0]), 32'h81);

        // Aborted read-data frame must leave the read-address flag set
        run_frame(1'b1, 10'b10_0000_0000, 10, 12);
        check("abort_rdadd_rx", 32'(rx_seen), 32'd1);
        run_frame(1'b1, 10'b11_0000_0000, 5, 0);
        check("abort_rddata_rx", 32'(rx_seen), 32'd0);
        check("abort_rddata_tx", 32'(tx_seen), 32'd0);
        check("abort_rddata_miso", miso_log, 32'd0);
        run_frame(1'b1, 10'b11_0000_0000, 10, 12);
        check("after_abort_miso", miso_log, 32'h81 << 4);

        // Reset while a read byte is being shifted out
        run_frame(1'b1, 10'b10_1111_1111, 10, 12);
        clear_obs();
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b1);
        bits = 10'b11_0000_0000;
        for (int i = 0; i < 10; i++) cycle(1'b0, bits[9-i]);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0);
        check("pre_reset_miso", 32'(MISO), 32'd1);
        wrst_n = 1'b0;
        #1;
        check("midreset_miso", 32'(MISO), 32'd0);
        check("midreset_state", 32'(dut.state), 32'(IDLE));
        check("midreset_flag", 32'(dut.rd_addr_flag), 32'd0);
        SS_n = 1'b1;
        repeat (2) @(posedge wclk);
        #1;
        check("midreset_held_miso", 32'(MISO), 32'd0);
        wrst_n = 1'b1;
        cycle(1'b1, 1'b0);

        // Addresses and flag are back to zero, so this writes mem[0] and reads it back
        run_frame(1'b0, 10'b01_0101_1010, 10, 12);
        check("post_reset_wr_rx", 32'(rx_seen), 32'd1);
        run_frame(1'b1, 10'b10_0000_0000, 10, 12);
        check("post_reset_rdadd_tx", 32'(tx_seen), 32'd0);
        run_frame(1'b1, 10'b11_0000_0000, 10, 12);
        check("post_reset_tx", 32'(tx_seen), 32'd1);
        check("post_reset_miso", miso_log, 32'h5A << 4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spi_wrapper.md
SPI_WRAPPER -- requirements
Module: spi_wrapper

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 256, meaning RAM word count.
REQ-002 SHALL have parameter ADDR_SIZE, default 8, meaning RAM address width.
REQ-003 SHALL have port wclk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port wrst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port SS_n  input  1  slave select, active-low, frames a transaction.
REQ-006 SHALL have port MOSI  input  1  serial data in, MSB first.
REQ-007 SHALL have port MISO  output  1  serial read data out, MSB first.

Function
REQ-008 SHALL implement FSM states IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
REQ-009 SHALL go IDLE->CHK_CMD on the first rising edge with SS_n=0.
REQ-010 In CHK_CMD, SHALL sample MOSI: 0 -> WRITE; 1 -> READ_ADD if read-address flag clear, else READ_DATA.
REQ-011 In WRITE/READ_ADD/READ_DATA, SHALL shift in exactly 10 MOSI bits, MSB first, into din[9:0]: din[9:8] command, din[7:0] payload.
REQ-012 SHALL register din and a one-cycle rx_valid pulse on the edge after the 10th bit is sampled.
REQ-013 SHALL discard the frame (no rx_valid) when din[9] differs from the CHK_CMD select bit.
REQ-014 Commands: 00 store write address; 01 write payload to mem[write address]; 10 store read address; 11 read mem[read address].
REQ-015 RAM SHALL act on the rising edge where rx_valid=1; command 11 registers dout and a one-cycle tx_valid pulse.
REQ-016 Read-address flag SHALL set on a completed READ_ADD frame and clear on a completed READ_DATA frame.
REQ-017 In READ_DATA, the edge after tx_valid SHALL drive MISO=dout[7], then dout[6..0] on the next 7 edges.
REQ-018 MISO SHALL be 0 whenever no read byte is being shifted.
REQ-019 SS_n=1 in any state SHALL return the FSM to IDLE on the next edge, aborting a partial frame (no rx_valid, no MISO).
REQ-020 After the 10th bit, the FSM SHALL remain in its state, ignoring MOSI, until SS_n=1.
REQ-021 Addresses SHALL be ADDR_SIZE bits, no wrap or range checking.

Reset
REQ-022 wrst_n=0 SHALL immediately force IDLE, MISO=0, rx_valid=0, tx_valid=0, dout=0, din=0, bit counters=0, read-address flag=0, stored addresses=0.
REQ-023 Memory contents SHALL NOT be reset.
REQ-024 Reset mid-frame SHALL discard the frame.

Configuration
REQ-025 With SPI_ASSERT_EN defined, SHALL compile assertions: rx_valid one-cycle only, tx_valid only after command 11, MISO=0 outside READ_DATA, state always legal.
REQ-026 Without SPI_ASSERT_EN, SHALL contain no checking logic, with identical functional behaviour.

Structure
REQ-027 Package spi_pkg SHALL hold the state enum, command encodings (00/01/10/11) and default MEM_DEPTH/ADDR_SIZE constants.
REQ-028 SHALL instantiate one sub-module spi_ram (single-port MEM_DEPTH x 8, din/rx_valid in, dout/tx_valid out); the serial FSM resides in spi_wrapper.

Verification
REQ-029 Reset asserted mid-frame -> IDLE, MISO=0, next frame decodes normally.
REQ-030 Frame select 0, bits 00_0110_0111 -> write address 0x67 stored.
REQ-031 Frame select 0, bits 01_1111_1111 -> mem[0x67]=0xFF.
REQ-032 Frame select 1, bits 10_0110_0111, then frame select 1, bits 11_0110_0111, SS_n low 10 more cycles -> MISO shows 1,1,1,1,1,1,1,1 on 8 consecutive edges, then 0.
REQ-033 SS_n raised after 5 bits -> no rx_valid, memory and address registers unchanged.
REQ-034 Frame select 0 with bits 11_xxxx_xxxx -> frame discarded, no tx_valid.
